// File: rtl/mem_stage_skid.sv
// Memory-stage pipeline register: valid/ready handshake, two-entry skid buffer,
// global stall enable and synchronous flush.
module mem_stage_skid #(
    parameter int DATA_W      = 36,
    parameter bit FLUSH_CLEAR = 1'b1
) (
    input  logic              stg_clk,
    input  logic              reset,
    input  logic              stg_ena,
    input  logic              stg_x,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    // The state encoding is the valid pair {s_valid, m_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] s_data;
    logic [DATA_W-1:0] m_data_next;
    logic [DATA_W-1:0] s_data_next;
    logic              m_valid;
    logic              s_valid;
    logic              acc;
    logic              emit;

    assign m_valid   = state[0];
    assign s_valid   = state[1];
    assign in_ready  = stg_ena & ~s_valid;
    assign out_valid = stg_ena & m_valid;
    assign out_data  = m_data;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
    assign acc       = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            m_data <= '0;
            s_data <= '0;
        end else begin
            state  <= state_next;
            m_data <= m_data_next;
            s_data <= s_data_next;
        end
    end

    // Flush wins over stall; an entry emitted during the flush cycle counts as consumed.
    always_comb begin
        state_next  = state;
        m_data_next = m_data;
        s_data_next = s_data;
        if (stg_x) begin
            state_next = EMPTY;
            if (FLUSH_CLEAR) begin
                m_data_next = '0;
                s_data_next = '0;
            end
        end else if (stg_ena) begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        m_data_next = in_data;
                        state_next  = ONE;
                    end
                end
                ONE: begin
                    if (acc && emit) begin
                        m_data_next = in_data;
                    end else if (acc) begin
                        s_data_next = in_data;
                        state_next  = TWO;
                    end else if (emit) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        m_data_next = s_data;
                        state_next  = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_skid.sv
// Directed bench for mem_stage_skid; a FLUSH_CLEAR=1 and a FLUSH_CLEAR=0 instance
// share one stimulus stream.
module tb_mem_stage_skid;

    localparam int DATA_W = 36;

    logic              stg_clk = 1'b0;
    logic              reset;
    logic              stg_ena;
    logic              stg_x;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              in_ready_c;
    logic              out_valid_c;
    logic [DATA_W-1:0] out_data_c;
    logic [1:0]        occupancy_c;
    logic              in_ready_h;
    logic              out_valid_h;
    logic [DATA_W-1:0] out_data_h;
    logic [1:0]        occupancy_h;
    int                checks   = 0;
    int                failures = 0;

    always #5 stg_clk = ~stg_clk;

    mem_stage_skid #(.DATA_W(DATA_W), .FLUSH_CLEAR(1'b1)) dut_clear (
        .stg_clk  (stg_clk),
        .reset    (reset),
        .stg_ena  (stg_ena),
        .stg_x    (stg_x),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready_c),
        .out_valid(out_valid_c),
        .out_data (out_data_c),
        .out_ready(out_ready),
        .occupancy(occupancy_c)
    );

    mem_stage_skid #(.DATA_W(DATA_W), .FLUSH_CLEAR(1'b0)) dut_hold (
        .stg_clk  (stg_clk),
        .reset    (reset),
        .stg_ena  (stg_ena),
        .stg_x    (stg_x),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready_h),
        .out_valid(out_valid_h),
        .out_data (out_data_h),
        .out_ready(out_ready),
        .occupancy(occupancy_h)
    );

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Handshake status of both instances, which only differ in flush data.
    task automatic check_status(input string tag, input logic rdy, input logic vld, input logic [1:0] occ);
        check_output({tag, " in_ready"},  64'(in_ready_c),  64'(rdy));
        check_output({tag, " out_valid"}, 64'(out_valid_c), 64'(vld));
        check_output({tag, " occupancy"}, 64'(occupancy_c), 64'(occ));
        check_output({tag, " occ_hold"},  64'(occupancy_h), 64'(occ));
    endtask

    task automatic apply_stimulus(input logic vld, input logic [DATA_W-1:0] data, input logic ordy,
                                  input logic ena, input logic x);
        in_valid  = vld;
        in_data   = data;
        out_ready = ordy;
        stg_ena   = ena;
        stg_x     = x;
        #1;
    endtask

    task automatic tick();
        @(posedge stg_clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        #10;
        check_status("reset", 1'b1, 1'b0, 2'd0);
        check_output("reset out_data", 64'(out_data_c), 64'h0);
        reset = 1'b0;

        // single entry
        apply_stimulus(1'b1, 36'h8_0000_1004, 1'b1, 1'b1, 1'b0);
        check_status("single pre", 1'b1, 1'b0, 2'd0);
        tick();
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_status("single out", 1'b1, 1'b1, 2'd1);
        check_output("single data", 64'(out_data_c), 64'h8_0000_1004);
        tick();
        check_status("single drained", 1'b1, 1'b0, 2'd0);

        // streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, DATA_W'(i), 1'b1, 1'b1, 1'b0);
            if (i > 1) begin
                check_status("stream", 1'b1, 1'b1, 2'd1);
                check_output("stream data", 64'(out_data_c), 64'(i - 1));
            end else begin
                check_status("stream first", 1'b1, 1'b0, 2'd0);
            end
            tick();
        end
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_status("stream last", 1'b1, 1'b1, 2'd1);
        check_output("stream last data", 64'(out_data_c), 64'd8);
        tick();
        check_status("stream end", 1'b1, 1'b0, 2'd0);

        // back-pressure fills the skid
        apply_stimulus(1'b1, 36'hA, 1'b0, 1'b1, 1'b0);
        check_status("bp A", 1'b1, 1'b0, 2'd0);
        tick();
        apply_stimulus(1'b1, 36'hB, 1'b0, 1'b1, 1'b0);
        check_status("bp B", 1'b1, 1'b1, 2'd1);
        check_output("bp B head", 64'(out_data_c), 64'hA);
        tick();
        apply_stimulus(1'b1, 36'hC, 1'b0, 1'b1, 1'b0);
        check_status("bp C", 1'b0, 1'b1, 2'd2);
        tick();

        // stall with both entries held
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 36'hC, 1'b1, 1'b0, 1'b0);
            check_status("stall", 1'b0, 1'b0, 2'd2);
            tick();
        end

        // drain in order while upstream still holds C
        apply_stimulus(1'b1, 36'hC, 1'b1, 1'b1, 1'b0);
        check_status("drain A", 1'b0, 1'b1, 2'd2);
        check_output("drain A data", 64'(out_data_c), 64'hA);
        tick();
        apply_stimulus(1'b1, 36'hC, 1'b1, 1'b1, 1'b0);
        check_status("drain B", 1'b1, 1'b1, 2'd1);
        check_output("drain B data", 64'(out_data_c), 64'hB);
        tick();
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_status("drain C", 1'b1, 1'b1, 2'd1);
        check_output("drain C data", 64'(out_data_c), 64'hC);
        tick();
        check_status("drain end", 1'b1, 1'b0, 2'd0);

        // flush with simultaneous input
        apply_stimulus(1'b1, 36'h11, 1'b0, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b1, 36'h22, 1'b0, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b1, 36'h33, 1'b0, 1'b1, 1'b1);
        check_status("flush pre", 1'b0, 1'b1, 2'd2);
        tick();
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_status("flush post", 1'b1, 1'b0, 2'd0);
        check_output("flush clear data", 64'(out_data_c), 64'h0);
        check_output("flush hold data", 64'(out_data_h), 64'h11);
        check_output("flush hold valid", 64'(out_valid_h), 64'h0);
        tick();
        check_status("flush idle", 1'b1, 1'b0, 2'd0);
        apply_stimulus(1'b1, 36'h44, 1'b1, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_status("post flush", 1'b1, 1'b1, 2'd1);
        check_output("post flush data", 64'(out_data_c), 64'h44);
        check_output("post flush hold data", 64'(out_data_h), 64'h44);
        tick();
        check_status("post flush end", 1'b1, 1'b0, 2'd0);

        // asynchronous reset with both entries held
        apply_stimulus(1'b1, 36'h55, 1'b0, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b1, 36'h66, 1'b0, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_status("areset pre", 1'b0, 1'b1, 2'd2);
        #1 reset = 1'b1;
        #1;
        check_status("areset", 1'b1, 1'b0, 2'd0);
        check_output("areset clear data", 64'(out_data_c), 64'h0);
        check_output("areset hold data", 64'(out_data_h), 64'h0);
        #1 reset = 1'b0;
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        check_status("areset after", 1'b1, 1'b0, 2'd0);
        tick();
        check_status("areset after2", 1'b1, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
